// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : dmem_arbiter
// Brief   : Two-requester (CPU / debug) data-memory arbiter with a rotating
//           priority pointer, debug priority lock and 1-cycle read return.
// Revision: 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    input  logic              dbg_lock,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rden,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q
);

    logic r_prio;
    logic r_rd_pending;
    logic r_rd_owner;
    logic w_cpu_win;
    logic w_dbg_win;
    logic w_gnt_we;

    // Grants are gated by rst so every output is forced low while reset is held.
    always_comb begin
        w_cpu_win = 1'b0;
        w_dbg_win = 1'b0;
        if (!rst) begin
            if (cpu_req && (!dbg_req || !r_prio)) begin
                w_cpu_win = 1'b1;
            end else if (dbg_req) begin
                w_dbg_win = 1'b1;
            end
        end
    end

    always_comb begin
        w_gnt_we  = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_cpu_win) begin
            w_gnt_we  = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (w_dbg_win) begin
            w_gnt_we  = dbg_we;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
        end
    end

    assign cpu_gnt  = w_cpu_win;
    assign dbg_gnt  = w_dbg_win;
    assign mem_wren = (w_cpu_win | w_dbg_win) & w_gnt_we;
    assign mem_rden = (w_cpu_win | w_dbg_win) & ~w_gnt_we;

    // Debug keeps the pointer on itself only while it asserts dbg_lock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prio       <= 1'b0;
            r_rd_pending <= 1'b0;
            r_rd_owner   <= 1'b0;
        end else begin
            if (w_cpu_win) begin
                r_prio <= 1'b1;
            end else if (w_dbg_win) begin
                r_prio <= dbg_lock;
            end
            r_rd_pending <= mem_rden;
            r_rd_owner   <= w_dbg_win;
        end
    end

    assign cpu_rvalid = r_rd_pending & ~r_rd_owner;
    assign dbg_rvalid = r_rd_pending &  r_rd_owner;
    assign cpu_rdata  = cpu_rvalid ? mem_q : '0;
    assign dbg_rdata  = dbg_rvalid ? mem_q : '0;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_dmem_arbiter
// Brief   : Self-checking bench: directed vector table, randomized cycles
//           against a reference model, and asynchronous reset sequence.
// Revision: 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    typedef struct {
        logic        creq, cwe;
        logic [7:0]  caddr;
        logic [31:0] cwd;
        logic        dreq, dwe;
        logic [7:0]  daddr;
        logic [31:0] dwd;
        logic        lock;
        logic [31:0] mq;
        logic [1:0]  egnt;   // {dbg, cpu}
        logic [7:0]  eaddr;
        logic [31:0] ewd;
        logic        ewr, erd;
        logic [1:0]  erv;    // {dbg, cpu}
        logic [31:0] erdata;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we, dbg_req, dbg_we, dbg_lock;
    logic [7:0]  cpu_addr, dbg_addr, mem_addr;
    logic [31:0] cpu_wdata, dbg_wdata, mem_wdata, mem_q, cpu_rdata, dbg_rdata;
    logic        cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid, mem_rden, mem_wren;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_lock(dbg_lock), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rden(mem_rden), .mem_wren(mem_wren),
        .mem_q(mem_q)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic creq, cwe, input logic [7:0] caddr, input logic [31:0] cwd,
                                input logic dreq, dwe, input logic [7:0] daddr, input logic [31:0] dwd,
                                input logic lock, input logic [31:0] mq,
                                input logic [1:0] egnt, input logic [7:0] eaddr, input logic [31:0] ewd,
                                input logic ewr, erd, input logic [1:0] erv, input logic [31:0] erdata);
        vec_t v;
        v.creq = creq; v.cwe = cwe; v.caddr = caddr; v.cwd = cwd;
        v.dreq = dreq; v.dwe = dwe; v.daddr = daddr; v.dwd = dwd;
        v.lock = lock; v.mq = mq;
        v.egnt = egnt; v.eaddr = eaddr; v.ewd = ewd; v.ewr = ewr; v.erd = erd;
        v.erv = erv; v.erdata = erdata;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        cpu_req = v.creq; cpu_we = v.cwe; cpu_addr = v.caddr; cpu_wdata = v.cwd;
        dbg_req = v.dreq; dbg_we = v.dwe; dbg_addr = v.daddr; dbg_wdata = v.dwd;
        dbg_lock = v.lock; mem_q = v.mq;
    endtask

    task automatic check_vec(input string tag, input vec_t v);
        chk({tag, " gnt"},        {30'd0, dbg_gnt, cpu_gnt}, {30'd0, v.egnt});
        chk({tag, " mem_addr"},   {24'd0, mem_addr}, {24'd0, v.eaddr});
        chk({tag, " mem_wdata"},  mem_wdata, v.ewd);
        chk({tag, " wren/rden"},  {30'd0, mem_wren, mem_rden}, {30'd0, v.ewr, v.erd});
        chk({tag, " rvalid"},     {30'd0, dbg_rvalid, cpu_rvalid}, {30'd0, v.erv});
        chk({tag, " cpu_rdata"},  cpu_rdata, v.erv[0] ? v.erdata : 32'd0);
        chk({tag, " dbg_rdata"},  dbg_rdata, v.erv[1] ? v.erdata : 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " outs"}, {26'd0, cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid, mem_rden, mem_wren}, 32'd0);
        chk({tag, " mem_addr"},  {24'd0, mem_addr}, 32'd0);
        chk({tag, " mem_wdata"}, mem_wdata, 32'd0);
        chk({tag, " rdata"},     cpu_rdata | dbg_rdata, 32'd0);
    endtask

    vec_t tbl[25];

    // Reference model state: priority pointer and owner of the read in flight.
    int m_prio;
    int m_pend;   // 0 none, 1 cpu, 2 dbg

    initial begin
        vec_t v;
        int   win;
        tbl[0]  = mk(1,1,8'h10,32'hDEADBEEF, 0,0,8'h00,32'h0, 0,32'h0,      2'b01,8'h10,32'hDEADBEEF,1,0,2'b00,32'h0);
        tbl[1]  = mk(0,0,8'h00,32'h0,        0,0,8'h00,32'h0, 0,32'h12345678,2'b00,8'h00,32'h0,       0,0,2'b00,32'h0);
        tbl[2]  = mk(1,0,8'h10,32'h55,       0,0,8'h00,32'h0, 0,32'h0,      2'b01,8'h10,32'h55,      0,1,2'b00,32'h0);
        tbl[3]  = mk(0,0,8'h00,32'h0,        0,0,8'h00,32'h0, 0,32'hDEADBEEF,2'b00,8'h00,32'h0,      0,0,2'b01,32'hDEADBEEF);
        tbl[4]  = mk(0,0,8'h00,32'h0,        1,1,8'h20,32'hA5,0,32'h0,      2'b10,8'h20,32'hA5,      1,0,2'b00,32'h0);
        tbl[5]  = mk(1,1,8'h30,32'h1,        1,1,8'h40,32'h2, 0,32'h0,      2'b01,8'h30,32'h1,       1,0,2'b00,32'h0);
        tbl[6]  = mk(1,1,8'h30,32'h1,        1,1,8'h40,32'h2, 0,32'h0,      2'b10,8'h40,32'h2,       1,0,2'b00,32'h0);
        tbl[7]  = mk(1,1,8'h30,32'h1,        1,1,8'h40,32'h2, 0,32'h0,      2'b01,8'h30,32'h1,       1,0,2'b00,32'h0);
        tbl[8]  = mk(1,1,8'h30,32'h1,        1,1,8'h40,32'h2, 0,32'h0,      2'b10,8'h40,32'h2,       1,0,2'b00,32'h0);
        tbl[9]  = mk(1,1,8'h31,32'h3,        1,1,8'h41,32'h4, 1,32'h0,      2'b01,8'h31,32'h3,       1,0,2'b00,32'h0);
        tbl[10] = mk(1,1,8'h31,32'h3,        1,1,8'h41,32'h4, 1,32'h0,      2'b10,8'h41,32'h4,       1,0,2'b00,32'h0);
        tbl[11] = mk(1,1,8'h31,32'h3,        1,1,8'h41,32'h4, 1,32'h0,      2'b10,8'h41,32'h4,       1,0,2'b00,32'h0);
        tbl[12] = mk(1,1,8'h31,32'h3,        1,1,8'h41,32'h4, 1,32'h0,      2'b10,8'h41,32'h4,       1,0,2'b00,32'h0);
        tbl[13] = mk(0,0,8'h00,32'h0,        1,1,8'h42,32'h5, 0,32'h0,      2'b10,8'h42,32'h5,       1,0,2'b00,32'h0);
        tbl[14] = mk(1,1,8'h32,32'h6,        1,1,8'h43,32'h7, 1,32'h0,      2'b01,8'h32,32'h6,       1,0,2'b00,32'h0);
        tbl[15] = mk(1,1,8'h32,32'h6,        1,1,8'h43,32'h7, 1,32'h0,      2'b10,8'h43,32'h7,       1,0,2'b00,32'h0);
        tbl[16] = mk(1,1,8'h32,32'h6,        1,1,8'h43,32'h7, 0,32'h0,      2'b10,8'h43,32'h7,       1,0,2'b00,32'h0);
        tbl[17] = mk(1,1,8'h32,32'h6,        1,1,8'h43,32'h7, 0,32'h0,      2'b01,8'h32,32'h6,       1,0,2'b00,32'h0);
        tbl[18] = mk(1,0,8'h01,32'h0,        0,0,8'h00,32'h0, 0,32'h0,      2'b01,8'h01,32'h0,       0,1,2'b00,32'h0);
        tbl[19] = mk(0,0,8'h00,32'h0,        1,0,8'h02,32'h0, 0,32'h11,     2'b10,8'h02,32'h0,       0,1,2'b01,32'h11);
        tbl[20] = mk(0,0,8'h00,32'h0,        0,0,8'h00,32'h0, 0,32'h22,     2'b00,8'h00,32'h0,       0,0,2'b10,32'h22);
        tbl[21] = mk(0,0,8'h00,32'h0,        0,0,8'h00,32'h0, 0,32'h33,     2'b00,8'h00,32'h0,       0,0,2'b00,32'h0);
        tbl[22] = mk(1,0,8'h05,32'h7,        1,0,8'h06,32'h8, 0,32'h99,     2'b01,8'h05,32'h7,       0,1,2'b00,32'h0);
        tbl[23] = mk(1,0,8'h05,32'h7,        1,0,8'h06,32'h8, 0,32'hAB,     2'b10,8'h06,32'h8,       0,1,2'b01,32'hAB);
        tbl[24] = mk(0,0,8'h00,32'h0,        0,0,8'h00,32'h0, 0,32'hCD,     2'b00,8'h00,32'h0,       0,0,2'b10,32'hCD);

        // Reset held with every request active: outputs must stay low.
        rst = 1'b1;
        apply(mk(1,1,8'hFF,32'hFFFFFFFF, 1,0,8'hEE,32'hEEEEEEEE, 1,32'hCAFEF00D,
                 2'b00,8'h0,32'h0,0,0,2'b00,32'h0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset_hold");
        rst = 1'b0;

        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            apply(tbl[i]);
            @(negedge clk);
            check_vec($sformatf("vec%0d", i), tbl[i]);
        end

        m_prio = 0;
        m_pend = 0;
        for (int c = 0; c < 300; c++) begin
            @(posedge clk); #1;
            v.creq = 1'($urandom); v.cwe = 1'($urandom); v.caddr = 8'($urandom); v.cwd = $urandom;
            v.dreq = 1'($urandom); v.dwe = 1'($urandom); v.daddr = 8'($urandom); v.dwd = $urandom;
            v.lock = 1'($urandom); v.mq = $urandom;
            if (v.creq && v.dreq)   win = (m_prio == 1) ? 2 : 1;
            else if (v.creq)        win = 1;
            else if (v.dreq)        win = 2;
            else                    win = 0;
            v.egnt   = (win == 1) ? 2'b01 : (win == 2) ? 2'b10 : 2'b00;
            v.eaddr  = (win == 1) ? v.caddr : (win == 2) ? v.daddr : 8'h0;
            v.ewd    = (win == 1) ? v.cwd   : (win == 2) ? v.dwd   : 32'h0;
            v.ewr    = (win == 1) ? v.cwe : (win == 2) ? v.dwe : 1'b0;
            v.erd    = (win == 1) ? !v.cwe : (win == 2) ? !v.dwe : 1'b0;
            v.erv    = (m_pend == 1) ? 2'b01 : (m_pend == 2) ? 2'b10 : 2'b00;
            v.erdata = v.mq;
            apply(v);
            @(negedge clk);
            check_vec($sformatf("rnd%0d", c), v);
            if (win == 1)      m_prio = 1;
            else if (win == 2) m_prio = v.lock ? 1 : 0;
            m_pend = v.erd ? win : 0;
        end

        // Read granted, then reset pulsed between edges: the return is dropped.
        @(posedge clk); #1;
        apply(mk(1,0,8'h44,32'h0, 0,0,8'h0,32'h0, 1,32'h0, 2'b01,8'h44,32'h0,0,1,2'b00,32'h0));
        #2;
        chk("rst_pre gnt", {31'd0, cpu_gnt}, 32'd1);
        chk("rst_pre rden", {31'd0, mem_rden}, 32'd1);
        rst = 1'b1;
        #1;
        check_all_zero("rst_async");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        apply(mk(0,0,8'h0,32'h0, 0,0,8'h0,32'h0, 0,32'h77777777, 2'b00,8'h0,32'h0,0,0,2'b00,32'h0));
        #1;
        chk("rst_release rvalid", {30'd0, dbg_rvalid, cpu_rvalid}, 32'd0);
        @(posedge clk); #1;
        chk("rst_after_edge rvalid", {30'd0, dbg_rvalid, cpu_rvalid}, 32'd0);
        apply(mk(1,1,8'h50,32'h9, 1,1,8'h60,32'hA, 1,32'h0, 2'b01,8'h50,32'h9,1,0,2'b00,32'h0));
        @(negedge clk);
        check_vec("rst_first_contend", mk(1,1,8'h50,32'h9, 1,1,8'h60,32'hA, 1,32'h0,
                                          2'b01,8'h50,32'h9,1,0,2'b00,32'h0));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: ADDR_W, 8, data-memory word-address width.
REQ-002 Parameter: DATA_W, 32, data-memory word width.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 cpu_req  input  1  processor access request, valid for the current cycle only.
REQ-006 cpu_we  input  1  1 = write, 0 = read; qualified by cpu_req.
REQ-007 cpu_addr  input  ADDR_W  processor word address.
REQ-008 cpu_wdata  input  DATA_W  processor write data.
REQ-009 cpu_gnt  output  1  processor access issued this cycle.
REQ-010 cpu_rvalid  output  1  processor read data valid.
REQ-011 cpu_rdata  output  DATA_W  processor read data.
REQ-012 dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_gnt, dbg_rvalid, dbg_rdata: same directions, widths and meanings as the cpu_* ports, for the debug/loader requester.
REQ-013 dbg_lock  input  1  debug requester asks to keep priority after its grant.
REQ-014 mem_addr  output  ADDR_W  address to data memory.
REQ-015 mem_wdata  output  DATA_W  write data to data memory.
REQ-016 mem_rden  output  1  memory read enable.
REQ-017 mem_wren  output  1  memory write enable.
REQ-018 mem_q  input  DATA_W  memory read data; valid one clock after the read is sampled.

Function
REQ-019 At most one of cpu_gnt and dbg_gnt SHALL be 1 in any cycle.
REQ-020 Grant SHALL be combinational from the req inputs and the registered priority pointer prio (0 = CPU first, 1 = DBG first).
- Only one requester active: that requester is granted.
- Both active: the requester selected by prio is granted.
- Neither active: no grant.
REQ-021 mem_addr and mem_wdata SHALL carry the granted requester's addr/wdata; they SHALL be 0 when there is no grant.
REQ-022 On a granted write (we=1): mem_wren=1, mem_rden=0. On a granted read (we=0): mem_rden=1, mem_wren=0. With no grant, both SHALL be 0.
REQ-023 prio update at each clock edge:
- CPU granted: prio<=1.
- DBG granted with dbg_lock=0: prio<=0.
- DBG granted with dbg_lock=1: prio<=1 (DBG keeps priority).
- No grant: prio holds its value.
REQ-024 A one-stage return register SHALL record {rd_pending, rd_owner} at each edge: set when a read is granted, cleared otherwise.
REQ-025 The cycle after a granted read, the owner's rvalid SHALL be 1 and its rdata SHALL equal mem_q. The other requester's rvalid SHALL be 0.
REQ-026 When its rvalid is 0, a requester's rdata SHALL be 0.
REQ-027 Read latency SHALL be exactly 1 cycle from grant to rvalid. A granted write produces no rvalid.
REQ-028 Back-to-back reads SHALL be supported every cycle, with one rvalid per grant in grant order; the new grant and the previous return SHALL coexist in the same cycle.
REQ-029 An ungranted request SHALL NOT be queued. The requester SHALL hold req with stable addr, we and wdata until it sees gnt=1.

Reset
REQ-030 While rst=1, the following SHALL be 0 regardless of inputs: prio, rd_pending, both gnt, both rvalid, both rdata, mem_rden, mem_wren, mem_addr, mem_wdata.
REQ-031 Assertion of rst mid-operation SHALL discard any pending read return; no rvalid SHALL appear in the cycle after rst deasserts.
REQ-032 After rst deasserts, the first contended cycle SHALL grant CPU.

Verification
REQ-033 Reset, then cpu_req=1, cpu_we=1, cpu_addr=0x10, cpu_wdata=0xDEADBEEF -> same cycle: cpu_gnt=1, mem_wren=1, mem_addr=0x10, mem_wdata=0xDEADBEEF; next cycle: cpu_rvalid=0.
REQ-034 cpu read of 0x10 with mem_q=0xDEADBEEF returned -> cpu_gnt=1 and mem_rden=1 in cycle N; cpu_rvalid=1 and cpu_rdata=0xDEADBEEF in cycle N+1; dbg_rvalid=0.
REQ-035 Both req held high for 4 cycles, dbg_lock=0 -> grants alternate CPU, DBG, CPU, DBG; mem_addr follows the granted requester.
REQ-036 Both req held high for 4 cycles, dbg_lock=1 -> grants CPU, DBG, DBG, DBG; dropping dbg_lock in cycle 3 -> cycle 4 grants CPU.
REQ-037 Alternating reads CPU@0x01 then DBG@0x02 in consecutive cycles, with mem_q=0x11 then 0x22 -> cpu_rvalid with 0x11, then dbg_rvalid with 0x22, in consecutive cycles; never both rvalid at once.
REQ-038 Read granted, then rst pulsed asynchronously mid-cycle before the next edge -> all outputs 0 immediately; no rvalid after release; prio=0.
